// File: rtl/control_sequencer.sv
// Hardwired control sequencer for a small 16-bit datapath.
// Fetches a 16-bit instruction as two bytes (T0 low, T1 high). From T2 it
// decodes IR[15:10] and drives the RF, ALU, ARF, IR, memory and mux controls.
// HLT parks the sequencer in HALT until Reset.
// Ports:
//   Clock, Reset (sync, active-low)     clock and reset
//   IROut[15:0], FlagsOut[3:0]          instruction register, ALU flags {Z,C,N,O}
//   RF_* / ALU_* / ARF_* / IR_* / Mem_* / Mux*Sel   datapath controls (combinational)
//   SeqT[2:0], Halted                   current step and halt status (registered)
module control_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  FlagsOut,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  SeqT,
  output logic        Halted
);

  localparam int unsigned SEQ_W = 2;

  localparam logic [5:0] OP_BRA  = 6'h00;
  localparam logic [5:0] OP_BNE  = 6'h01;
  localparam logic [5:0] OP_LDR  = 6'h02;
  localparam logic [5:0] OP_STR  = 6'h03;
  localparam logic [5:0] OP_ADD  = 6'h04;
  localparam logic [5:0] OP_SUB  = 6'h05;
  localparam logic [5:0] OP_AND  = 6'h06;
  localparam logic [5:0] OP_MOVL = 6'h07;
  localparam logic [5:0] OP_LDAR = 6'h08;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  localparam logic [2:0] FUN_INC   = 3'b001;
  localparam logic [2:0] FUN_LOAD  = 3'b010;
  localparam logic [2:0] FUN_CLEAR = 3'b011;
  localparam logic [2:0] FUN_LDLO  = 3'b101;

  localparam logic [4:0] ALU_PASSA = 5'b10000;
  localparam logic [4:0] ALU_ADD   = 5'b10100;
  localparam logic [4:0] ALU_SUB   = 5'b10110;
  localparam logic [4:0] ALU_AND   = 5'b10111;

  typedef enum logic {ST_FETCH, ST_HALT} state_e;

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;

  logic [5:0] opcode;
  logic [1:0] rd, rs1, rs2;
  logic [3:0] rd_sel_n;
  logic       flag_z;
  logic       unused_bits;

  assign opcode   = IROut[15:10];
  assign rd       = IROut[9:8];
  assign rs1      = IROut[7:6];
  assign rs2      = IROut[5:4];
  assign flag_z   = FlagsOut[3];
  // Active-low RF write enable for Rd: R1 is bit 3, R4 is bit 0.
  assign rd_sel_n = ~(4'b1000 >> rd);
  assign unused_bits = ^{IROut[3:0], FlagsOut[2:0]};

  assign SeqT   = 3'(seq_q);
  assign Halted = (state_q == ST_HALT);

  // State and step register.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_FETCH;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
    end
  end

  // Next step: two fetch cycles, one execute cycle (two for MOVL), HLT parks at T2.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    if (state_q == ST_FETCH) begin
      case (seq_q)
        2'd0: seq_d = 2'd1;
        2'd1: seq_d = 2'd2;
        2'd2: begin
          if (opcode == OP_HLT) begin
            state_d = ST_HALT;
          end else if (opcode == OP_MOVL) begin
            seq_d = 2'd3;
          end else begin
            seq_d = 2'd0;
          end
        end
        default: seq_d = 2'd0;
      endcase
    end
  end

  // Control outputs; idle whenever Reset is low or the sequencer is halted.
  always_comb begin
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 3'b000;
    RF_RegSel   = 4'b1111;
    RF_ScrSel   = 4'b1111;
    ALU_FunSel  = 5'b00000;
    ALU_WF      = 1'b0;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 3'b000;
    ARF_RegSel  = 3'b111;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    if (Reset && (state_q == ST_FETCH)) begin
      case (seq_q)
        2'd0, 2'd1: begin
          // Fetch one IR byte from M[PC] and increment PC.
          ARF_OutDSel = 2'b00;
          Mem_CS      = 1'b0;
          IR_Write    = 1'b1;
          IR_LH       = seq_q[0];
          ARF_FunSel  = FUN_INC;
          ARF_RegSel  = 3'b011;
        end
        2'd2: begin
          case (opcode)
            OP_BRA, OP_BNE: begin
              if ((opcode == OP_BRA) || !flag_z) begin
                MuxBSel    = 2'b11;
                ARF_FunSel = FUN_LOAD;
                ARF_RegSel = 3'b011;
              end
            end
            OP_LDR: begin
              ARF_OutDSel = 2'b10;
              Mem_CS      = 1'b0;
              MuxASel     = 2'b10;
              RF_FunSel   = FUN_LOAD;
              RF_RegSel   = rd_sel_n;
            end
            OP_STR: begin
              RF_OutASel  = 3'(rd);
              ALU_FunSel  = ALU_PASSA;
              ARF_OutDSel = 2'b10;
              Mem_CS      = 1'b0;
              Mem_WR      = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              RF_OutASel = 3'(rs1);
              RF_OutBSel = 3'(rs2);
              ALU_FunSel = (opcode == OP_ADD) ? ALU_ADD :
                           (opcode == OP_SUB) ? ALU_SUB : ALU_AND;
              ALU_WF     = 1'b1;
              MuxASel    = 2'b00;
              RF_FunSel  = FUN_LOAD;
              RF_RegSel  = rd_sel_n;
            end
            OP_MOVL: begin
              RF_FunSel = FUN_CLEAR;
              RF_RegSel = rd_sel_n;
            end
            OP_LDAR: begin
              RF_OutASel = 3'(rd);
              ALU_FunSel = ALU_PASSA;
              MuxBSel    = 2'b00;
              ARF_FunSel = FUN_LOAD;
              ARF_RegSel = 3'b101;
            end
            default: ;
          endcase
        end
        default: begin
          // Second MOVL step: low byte of Rd from the immediate.
          if (opcode == OP_MOVL) begin
            MuxASel   = 2'b11;
            RF_FunSel = FUN_LDLO;
            RF_RegSel = rd_sel_n;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: an instruction-level model predicts
// every control output each cycle, and literal checks pin key cycles.
module tb_control_sequencer;

  typedef struct packed {
    logic [2:0] rf_outasel;
    logic [2:0] rf_outbsel;
    logic [2:0] rf_funsel;
    logic [3:0] rf_regsel;
    logic [3:0] rf_scrsel;
    logic [4:0] alu_funsel;
    logic       alu_wf;
    logic [1:0] arf_outcsel;
    logic [1:0] arf_outdsel;
    logic [2:0] arf_funsel;
    logic [2:0] arf_regsel;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] muxasel;
    logic [1:0] muxbsel;
    logic       muxcsel;
    logic [2:0] seqt;
    logic       halted;
  } ctrl_t;

  logic        clk;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  FlagsOut;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel, ARF_FunSel, ARF_RegSel, SeqT;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, MuxASel, MuxBSel;
  logic        ALU_WF, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxCSel, Halted;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;
  int m_step = 0;
  bit m_halt = 0;

  control_sequencer dut (
    .Clock(clk), .Reset(Reset), .IROut(IROut), .FlagsOut(FlagsOut),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
    .ALU_WF(ALU_WF), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
    .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
    .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .SeqT(SeqT), .Halted(Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctrl_t got;
  assign got = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
                ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
                ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxASel,
                MuxBSel, MuxCSel, SeqT, Halted};

  // Expected controls for one cycle, built from the instruction semantics.
  function automatic ctrl_t model(input logic rst, input int step, input bit halt,
                                  input logic [15:0] ir, input logic [3:0] fl);
    ctrl_t e;
    int op, rd, rs1, rs2;
    e = '0;
    e.rf_regsel  = 4'hF;
    e.rf_scrsel  = 4'hF;
    e.arf_regsel = 3'h7;
    e.mem_cs     = 1'b1;
    e.seqt       = 3'(step);
    e.halted     = halt;
    if (!rst || halt) return e;
    op  = int'(ir[15:10]);
    rd  = int'(ir[9:8]);
    rs1 = int'(ir[7:6]);
    rs2 = int'(ir[5:4]);
    if (step < 2) begin
      e.mem_cs = 1'b0; e.ir_write = 1'b1; e.ir_lh = (step == 1);
      e.arf_funsel = 3'd1; e.arf_regsel = 3'b011;
    end else if (step == 2) begin
      if (op == 0 || (op == 1 && !fl[3])) begin
        e.muxbsel = 2'b11; e.arf_funsel = 3'd2; e.arf_regsel = 3'b011;
      end else if (op == 2) begin
        e.arf_outdsel = 2'b10; e.mem_cs = 1'b0; e.muxasel = 2'b10;
        e.rf_funsel = 3'd2; e.rf_regsel = 4'hF ^ 4'(1 << (3 - rd));
      end else if (op == 3) begin
        e.rf_outasel = 3'(rd); e.alu_funsel = 5'b10000; e.arf_outdsel = 2'b10;
        e.mem_cs = 1'b0; e.mem_wr = 1'b1;
      end else if (op >= 4 && op <= 6) begin
        e.rf_outasel = 3'(rs1); e.rf_outbsel = 3'(rs2);
        e.alu_funsel = (op == 4) ? 5'd20 : (op == 5) ? 5'd22 : 5'd23;
        e.alu_wf = 1'b1; e.rf_funsel = 3'd2;
        e.rf_regsel = 4'hF ^ 4'(1 << (3 - rd));
      end else if (op == 7) begin
        e.rf_funsel = 3'd3; e.rf_regsel = 4'hF ^ 4'(1 << (3 - rd));
      end else if (op == 8) begin
        e.rf_outasel = 3'(rd); e.alu_funsel = 5'b10000;
        e.arf_funsel = 3'd2; e.arf_regsel = 3'b101;
      end
    end else if (step == 3 && op == 7) begin
      e.muxasel = 2'b11; e.rf_funsel = 3'd5; e.rf_regsel = 4'hF ^ 4'(1 << (3 - rd));
    end
    return e;
  endfunction

  // Instruction-level step tracker: MOVL takes 4 steps, others 3, HLT parks at step 2.
  always @(posedge clk) begin
    if (!Reset) begin
      m_step = 0;
      m_halt = 0;
    end else if (!m_halt) begin
      if (m_step == 2 && IROut[15:10] == 6'h3F) m_halt = 1;
      else if (m_step == ((IROut[15:10] == 6'h07) ? 3 : 2)) m_step = 0;
      else m_step = m_step + 1;
    end
  end

  // Cycle compare against the model.
  always @(negedge clk) begin
    ctrl_t exp_c;
    if (cmp_en) begin
      exp_c = model(Reset, m_step, m_halt, IROut, FlagsOut);
      checks++;
      if (got !== exp_c) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t ir=%h got=%h exp=%h", $time, IROut, got, exp_c);
      end
    end
  end

  task automatic lit(input string nm, input logic [15:0] g, input logic [15:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, g, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction from T0 and run until the model is back at T0.
  task automatic run_instr(input logic [15:0] ir, input logic [3:0] fl);
    bit done;
    done = 0;
    IROut = ir;
    FlagsOut = fl;
    for (int i = 0; i < 8 && !done; i++) begin
      tick();
      if (m_step == 0 && !m_halt) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL run_timeout got=%0d exp=0 ir=%h", m_step, ir);
    end
  endtask

  initial begin
    Reset = 1'b0; IROut = 16'h0000; FlagsOut = 4'h0;
    tick();
    cmp_en = 1;
    tick(); #1;
    lit("rst_seqt", 16'(SeqT), 16'd0);
    lit("rst_memcs", 16'(Mem_CS), 16'd1);
    lit("rst_irwrite", 16'(IR_Write), 16'd0);

    // Fetch after release, then ADD R3,R1,R4.
    tick(); Reset = 1'b1; IROut = 16'h1234; #1;
    lit("t0_seqt", 16'(SeqT), 16'd0);
    lit("t0_irw_lh", 16'({IR_Write, IR_LH}), 16'b10);
    lit("t0_arf", 16'({ARF_RegSel, ARF_FunSel}), 16'b011_001);
    lit("t0_memcs", 16'(Mem_CS), 16'd0);
    tick(); #1;
    lit("t1_irw_lh", 16'({IR_Write, IR_LH}), 16'b11);
    lit("t1_arf", 16'({ARF_RegSel, ARF_FunSel}), 16'b011_001);
    tick(); #1;
    lit("add_sel", 16'({RF_OutASel, RF_OutBSel}), 16'b000_011);
    lit("add_alu", 16'({ALU_FunSel, ALU_WF}), 16'b10100_1);
    lit("add_regsel", 16'(RF_RegSel), 16'b1101);
    tick(); #1;
    lit("add_next_seqt", 16'(SeqT), 16'd0);

    // BNE taken/not-taken.
    IROut = 16'h0400; FlagsOut = 4'b1000;
    tick(); tick(); #1;
    lit("bne_z1_arf", 16'(ARF_RegSel), 16'b111);
    tick(); FlagsOut = 4'b0000;
    tick(); tick(); #1;
    lit("bne_z0", 16'({MuxBSel, ARF_RegSel, ARF_FunSel}), 16'b11_011_010);
    tick();

    // MOVL R3,#5A.
    IROut = 16'h1E5A;
    tick(); tick(); #1;
    lit("movl_t2", 16'({RF_FunSel, RF_RegSel}), 16'b011_1101);
    tick(); #1;
    lit("movl_t3", 16'({SeqT, RF_FunSel, MuxASel}), 16'b011_101_11);
    tick(); #1;
    lit("movl_next_seqt", 16'(SeqT), 16'd0);

    // Remaining opcodes under the model.
    run_instr(16'h0A00, 4'h0); // LDR R3
    run_instr(16'h0D00, 4'h0); // STR R2
    run_instr(16'h1660, 4'h0); // SUB R3,R2,R3
    run_instr(16'h1990, 4'hF); // AND R2,R3,R2
    run_instr(16'h2300, 4'h0); // LDAR R4
    run_instr(16'h0012, 4'h8); // BRA
    run_instr(16'h2400, 4'h0); // undefined
    run_instr(16'h1FFF, 4'h0); // MOVL R4,#FF

    // Reset during STR T2 suppresses the write.
    IROut = 16'h0D00;
    tick(); tick(); Reset = 1'b0; #1;
    lit("str_rst_mem", 16'({Mem_CS, Mem_WR}), 16'b10);
    tick(); Reset = 1'b1; #1;
    lit("str_rst_seqt", 16'(SeqT), 16'd0);

    // HLT parks at T2 until reset.
    IROut = 16'hFC00;
    tick(); tick(); #1;
    lit("hlt_t2", 16'({SeqT, Halted}), 16'b010_0);
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      lit("hlt_stuck", 16'({SeqT, Halted}), 16'b010_1);
    end
    Reset = 1'b0;
    tick(); Reset = 1'b1; IROut = 16'h1234; #1;
    lit("hlt_rst", 16'({SeqT, Halted, IR_Write}), 16'b000_0_1);
    tick(); #1;
    lit("hlt_rst_t1", 16'(SeqT), 16'd1);
    tick(); tick();

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
